// File: rtl/acc_cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | acc_cpu_pkg : opcodes, state encoding and width defaults for acc_cpu |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package acc_cpu_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_OPC_W  = 3;

  localparam logic [DEF_OPC_W-1:0] OP_HLT = 3'b000;
  localparam logic [DEF_OPC_W-1:0] OP_SKZ = 3'b001;
  localparam logic [DEF_OPC_W-1:0] OP_ADD = 3'b010;
  localparam logic [DEF_OPC_W-1:0] OP_LDA = 3'b011;
  localparam logic [DEF_OPC_W-1:0] OP_STO = 3'b100;
  localparam logic [DEF_OPC_W-1:0] OP_JMP = 3'b101;
  localparam logic [DEF_OPC_W-1:0] OP_NOP = 3'b110;
  localparam logic [DEF_OPC_W-1:0] OP_RSV = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LDIR   = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_STORE  = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/acc_cpu_pc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | acc_cpu_pc : program counter, sync load / wrapping increment         |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module acc_cpu_pc #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_inc,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pc <= '0;
    else if (i_load)
      r_pc <= i_load_val;
    else if (i_inc)
      r_pc <= r_pc + ADDR_W'(1);
  end

  assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/acc_cpu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | acc_cpu_ctrl : fetch/decode/execute sequencer of the accumulator CPU |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module acc_cpu_ctrl
  import acc_cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int OPC_W  = DEF_OPC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              acc_zero,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              acc_oe,
  output logic              alu_pass,
  output logic              alu_add,
  output logic              ld_acc,
  output logic              halted,
  output logic              busy,
  output logic [ADDR_W-1:0] pc_o
);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_ir;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] w_pc;
  logic              w_pc_inc;
  logic              w_pc_ld;
  logic [OPC_W-1:0]  w_opc;
  logic [ADDR_W-1:0] w_opd;

  assign w_opc = r_ir[DATA_W-1 -: OPC_W];
  assign w_opd = r_ir[ADDR_W-1:0];

  acc_cpu_pc #(.ADDR_W(ADDR_W)) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_inc      (w_pc_inc),
    .i_load     (w_pc_ld),
    .i_load_val (w_opd),
    .o_pc       (w_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ir        <= '0;
      r_addr_hold <= '0;
    end else begin
      r_state     <= w_next;
      r_addr_hold <= w_addr;
      if (r_state == ST_LDIR)
        r_ir <= mem_rdata;
    end
  end

  // acc_zero only steers the PC update; every output depends on registers alone
  always_comb begin
    w_next   = r_state;
    w_pc_inc = 1'b0;
    w_pc_ld  = 1'b0;
    w_addr   = r_addr_hold;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    acc_oe   = 1'b0;
    alu_pass = 1'b0;
    alu_add  = 1'b0;
    ld_acc   = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_FETCH;
      ST_FETCH: begin
        w_addr = w_pc;
        mem_rd = 1'b1;
        w_next = ST_LDIR;
      end
      ST_LDIR: begin
        w_pc_inc = 1'b1;
        w_next   = ST_DECODE;
      end
      ST_DECODE: begin
        w_next = ST_FETCH;
        case (w_opc)
          OPC_W'(OP_HLT): w_next = ST_HALT;
          OPC_W'(OP_SKZ): w_pc_inc = acc_zero;
          OPC_W'(OP_JMP): w_pc_ld = 1'b1;
          OPC_W'(OP_LDA), OPC_W'(OP_ADD): begin
            w_addr = w_opd;
            mem_rd = 1'b1;
            w_next = ST_EXEC;
          end
          OPC_W'(OP_STO): w_next = ST_STORE;
          default: w_next = ST_FETCH;
        endcase
      end
      ST_EXEC: begin
        alu_pass = (w_opc == OPC_W'(OP_LDA));
        alu_add  = (w_opc == OPC_W'(OP_ADD));
        ld_acc   = 1'b1;
        w_next   = ST_FETCH;
      end
      ST_STORE: begin
        w_addr = w_opd;
        mem_wr = 1'b1;
        acc_oe = 1'b1;
        w_next = ST_FETCH;
      end
      ST_HALT: if (start) w_next = ST_FETCH;
      default: w_next = ST_IDLE;
    endcase
  end

  assign mem_addr = w_addr;
  assign halted   = (r_state == ST_HALT);
  assign busy     = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign pc_o     = w_pc;

endmodule
`default_nettype wire

// File: doc/acc_cpu_ctrl.md
Name: acc_cpu_ctrl

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator machine.
- Owns the program counter (PC) and instruction register (IR).
- Drives the shared memory address/strobes and the ALU `pass`/`add` controls; also drives accumulator load/output-enable.
- Sits between the unified instruction/data memory and the ALU/accumulator datapath. ALU `a` = memory read data, ALU `b` = accumulator.

Parameters:
- ADDR_W, 5, memory address width; PC and IR operand field width.
- DATA_W, 8, instruction/data word width.
- OPC_W, 3, opcode width; instruction = {opcode[DATA_W-1 -: OPC_W], operand[ADDR_W-1:0]}.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins execution from IDLE or resumes from HALT.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_rd.
- acc_zero  in  1  accumulator == 0, from datapath.
- mem_addr  out  ADDR_W  memory address.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe; data = accumulator.
- acc_oe  out  1  accumulator drives memory write data.
- alu_pass  out  1  ALU pass (alu_out = a).
- alu_add  out  1  ALU add (alu_out = a + b, mod 2^DATA_W).
- ld_acc  out  1  load accumulator from alu_out at next edge.
- halted  out  1  high in HALT.
- busy  out  1  high in any state except IDLE and HALT.
- pc_o  out  ADDR_W  current PC (debug).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, PC=0, IR=0. All strobes, halted and busy are 0. mem_addr=0.
- Outputs are decoded from the registered state and IR only. There is no combinational path from any input to any output.
- Opcodes:
  - 000 HLT
  - 001 SKZ
  - 010 ADD
  - 011 LDA
  - 100 STO
  - 101 JMP
  - 110 NOP
  - 111 reserved, executes as NOP.
- States and transitions:
  - IDLE: wait. start=1 -> FETCH.
  - FETCH: mem_addr=PC, mem_rd=1 -> LDIR.
  - LDIR: IR<=mem_rdata, PC<=PC+1 (wraps 2^ADDR_W-1 -> 0) -> DECODE.
  - DECODE, by opcode:
    - HLT -> HALT.
    - NOP/reserved -> FETCH.
    - SKZ: if acc_zero, PC<=PC+1 (wrapping); -> FETCH.
    - JMP: PC<=IR operand -> FETCH.
    - LDA/ADD: mem_addr=operand, mem_rd=1 -> EXEC.
    - STO -> STORE.
  - EXEC: LDA drives alu_pass=1; ADD drives alu_add=1. ld_acc=1. -> FETCH. alu_pass and alu_add are never both 1.
  - STORE: mem_addr=operand, mem_wr=1, acc_oe=1 -> FETCH.
  - HALT: halted=1. start=1 -> FETCH, resuming at the current PC (the instruction after HLT).
- Latency in clocks, FETCH to next FETCH:
  - LDA/ADD/STO: 4.
  - SKZ/JMP/NOP: 3.
  - HLT: reaches HALT on the 3rd clock.
- start is ignored in every state except IDLE and HALT.
- mem_rd and mem_wr are never both 1.
- Address: mem_addr holds its last value when no strobe is active.
- Reset asserted mid-instruction:
  - Immediate return to IDLE with PC=0.
  - Any in-progress mem_wr/ld_acc is dropped in the same cycle (async).
- SKZ at PC = 2^ADDR_W-1 with acc_zero=1: PC wraps to 1.

Decomposition:
- Package acc_cpu_pkg:
  - opcode localparams (OP_HLT .. OP_RSV);
  - state encoding (ST_IDLE, ST_FETCH, ST_LDIR, ST_DECODE, ST_EXEC, ST_STORE, ST_HALT; 3-bit binary);
  - ADDR_W/DATA_W/OPC_W defaults.
- One sub-module, acc_cpu_pc: PC register with sync load, increment (wrapping) and async clear.
- FSM and output decode stay in the top.

Test Plan:
- Basic program. Memory:
  - mem[0]=LDA 5, mem[1]=ADD 6, mem[2]=STO 7, mem[3]=HLT;
  - mem[5]=3, mem[6]=4.
  - start -> mem[7]=7 after 4+4+4+3 clocks; halted=1; pc_o=4.
- SKZ skip: acc=0 (acc_zero=1), mem[0]=SKZ, mem[1]=HLT, mem[2]=JMP 9, mem[9]=HLT -> mem[1] is never fetched; halt with pc_o=10.
- PC wrap: mem[0]=JMP 31, mem[31]=NOP, and mem[0] re-read -> PC sequence 0,1,31,0 (repeats); busy stays 1.
- Reserved/start: opcode 111 behaves as NOP (3 clocks, no strobes). A start pulse mid-run changes nothing. start in HALT resumes at pc_o and fetches mem[pc_o].
- Reset mid-STORE: rst_n low during STORE -> mem_wr=0 in the same cycle, state IDLE, pc_o=0. The next start re-runs from address 0.
- Exclusivity checker over all runs: alu_pass & alu_add == 0, mem_rd & mem_wr == 0, and ld_acc only in EXEC.
